// File: rtl/mod_counter_defs.sv
// Shared definitions for the modulo index counter and the parity controllers
// that decode its value: digit width, digit packing helpers, step encoding.
package mod_counter_defs;

    // Bits needed to hold one digit of modulus m.
    function automatic int dig_w(input int m);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // Low bit of digit i inside a packed value of w-bit digits.
    function automatic int dig_lo(input int i, input int w);
        return i * w;
    endfunction

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN
    } step_e;

endpackage

// File: rtl/mod_counter_digit.sv
// One modulo-MOD digit: clear, load (out-of-range -> 0), step up/down with
// wrap pulse. Ports: clk, reset, clr, load, ld_digit, step_up, step_dn in;
// digit, wrap (registered), is_max, is_min (combinational) out.
module mod_counter_digit
    import mod_counter_defs::*;
#(
    parameter int MOD = 5,
    parameter int W   = dig_w(MOD)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] ld_digit,
    input  logic         step_up,
    input  logic         step_dn,
    output logic [W-1:0] digit,
    output logic         wrap,
    output logic         is_max,
    output logic         is_min
);

    localparam logic [W-1:0] MAXV = W'(MOD - 1);
    localparam logic [W:0]   MODV = (W + 1)'(MOD);

    logic [W-1:0] digit_q, digit_d;
    logic         wrap_q, wrap_d;

    assign is_max = (digit_q == MAXV);
    assign is_min = (digit_q == '0);

    always_comb begin
        digit_d = digit_q;
        wrap_d  = 1'b0;
        if (clr) begin
            digit_d = '0;
        end else if (load) begin
            digit_d = ({1'b0, ld_digit} >= MODV) ? '0 : ld_digit;
        end else if (step_up) begin
            if (is_max) begin
                digit_d = '0;
                wrap_d  = 1'b1;
            end else begin
                digit_d = digit_q + W'(1);
            end
        end else if (step_dn) begin
            if (is_min) begin
                digit_d = MAXV;
                wrap_d  = 1'b1;
            end else begin
                digit_d = digit_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            digit_q <= digit_d;
            wrap_q  <= wrap_d;
        end
    end

    assign digit = digit_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/mod_index_counter.sv
// Multi-digit modulo counter for matrix/lane index sweeps.
// Ports: clk, reset, clr, load, load_value, inc, dec in; value, digit_co,
// co, err (registered pulses) and at_max, at_min (combinational) out.
module mod_index_counter
    import mod_counter_defs::*;
#(
    parameter int MOD    = 5,
    parameter int DIGITS = 2,
    parameter int WRAP   = 1,
    localparam int W     = dig_w(MOD)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                load,
    input  logic [DIGITS*W-1:0] load_value,
    input  logic                inc,
    input  logic                dec,
    output logic [DIGITS*W-1:0] value,
    output logic [DIGITS-1:0]   digit_co,
    output logic                co,
    output logic                err,
    output logic                at_max,
    output logic                at_min
);

    localparam logic [W:0] MODV = (W + 1)'(MOD);

    logic [DIGITS-1:0] is_max, is_min, up_en, dn_en, oor;
    step_e             step;
    logic              co_q, co_d, err_q, err_d;

    assign at_max = &is_max;
    assign at_min = &is_min;

    // Saturating mode drops the step entirely at the terminal value.
    always_comb begin
        step = STEP_NONE;
        if (inc && !dec && (WRAP != 0 || !at_max))
            step = STEP_UP;
        else if (dec && !inc && (WRAP != 0 || !at_min))
            step = STEP_DN;
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        localparam int LO = dig_lo(i, W);

        // A digit steps only when every lower digit is at its turn-over value.
        if (i == 0) begin : g_lsd
            assign up_en[i] = (step == STEP_UP);
            assign dn_en[i] = (step == STEP_DN);
        end else begin : g_hi
            assign up_en[i] = up_en[i-1] & is_max[i-1];
            assign dn_en[i] = dn_en[i-1] & is_min[i-1];
        end

        assign oor[i] = ({1'b0, load_value[LO +: W]} >= MODV);

        mod_counter_digit #(.MOD(MOD), .W(W)) u_digit (
            .clk      (clk),
            .reset    (reset),
            .clr      (clr),
            .load     (load),
            .ld_digit (load_value[LO +: W]),
            .step_up  (up_en[i]),
            .step_dn  (dn_en[i]),
            .digit    (value[LO +: W]),
            .wrap     (digit_co[i]),
            .is_max   (is_max[i]),
            .is_min   (is_min[i])
        );
    end

    // Whole-counter wrap: stepping from the all-terminal value.
    assign co_d  = !clr && !load &&
                   ((step == STEP_UP && at_max) ||
                    (step == STEP_DN && at_min));
    assign err_d = !clr && load && (|oor);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            co_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            co_q  <= co_d;
            err_q <= err_d;
        end
    end

    assign co  = co_q;
    assign err = err_q;

endmodule
